// File: rtl/register_file_mp.sv
// Multi-port register file with a per-register pending scoreboard.
// Optional feature: define RF_BYPASS_EN for write-through reads (same-cycle
// writeback data forwarded to read ports, pending masked on release).
module register_file_mp #(
  parameter int unsigned REG_COUNT = 16,
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned NUM_RD    = 3,
  parameter int unsigned NUM_WR    = 2,
  localparam int unsigned PTR_W    = $clog2(REG_COUNT)
) (
  input  logic                        clk,
  input  logic                        reset_RF_n,
  input  logic                        flush,
  input  logic                        init_R0,
  input  logic [REG_WIDTH-1:0]        init_R0_data,
  input  logic [NUM_RD*PTR_W-1:0]     rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]           rd_pending,
  input  logic                        iss_valid,
  input  logic [PTR_W-1:0]            iss_dst,
  output logic                        issue_stall,
  input  logic [NUM_WR-1:0]           wb_valid,
  input  logic [NUM_WR*PTR_W-1:0]     wb_dst,
  input  logic [NUM_WR*REG_WIDTH-1:0] wb_data
);

  logic [REG_WIDTH-1:0] r [REG_COUNT];
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] wb_hit;
  logic [REG_COUNT-1:0] wr_hit;
  logic [REG_WIDTH-1:0] wr_val [REG_COUNT];
  logic                 issue_set;

  // Resolve the winning write per register: higher port wins, init_R0 tops R0
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      wb_hit[i] = 1'b0;
      wr_val[i] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (wb_valid[p] && (wb_dst[p*PTR_W +: PTR_W] == PTR_W'(i))) begin
          wb_hit[i] = 1'b1;
          wr_val[i] = wb_data[p*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
    wr_hit = wb_hit;
    if (init_R0) begin
      wr_hit[0] = 1'b1;
      wr_val[0] = init_R0_data;
    end
  end

  // Register storage update
  always_ff @(posedge clk or negedge reset_RF_n) begin
    if (!reset_RF_n) begin
      for (int i = 0; i < REG_COUNT; i++) r[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_hit[i]) r[i] <= wr_val[i];
      end
    end
  end

  assign issue_set = iss_valid && !issue_stall;

  // Scoreboard: a new reservation beats a same-edge release; flush beats both
  always_ff @(posedge clk or negedge reset_RF_n) begin
    if (!reset_RF_n) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (issue_set && (iss_dst == PTR_W'(i))) pending[i] <= 1'b1;
        else if (wb_hit[i])                      pending[i] <= 1'b0;
      end
    end
  end

  // Combinational read ports, forced to zero while reset is held
  always_comb begin
    logic [PTR_W-1:0] a;
    rd_data    = '0;
    rd_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = rd_addr[k*PTR_W +: PTR_W];
      if (reset_RF_n) begin
`ifdef RF_BYPASS_EN
        rd_data[k*REG_WIDTH +: REG_WIDTH] = wr_hit[a] ? wr_val[a] : r[a];
        rd_pending[k]                     = pending[a] & ~wb_hit[a];
`else
        rd_data[k*REG_WIDTH +: REG_WIDTH] = r[a];
        rd_pending[k]                     = pending[a];
`endif
      end
    end
  end

  assign issue_stall = (|rd_pending) | pending[iss_dst];

`ifndef SYNTHESIS
  // Per-register debug views for waveform inspection (g_dbg[i].r_unused)
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_dbg
    logic [REG_WIDTH-1:0] r_unused;
    assign r_unused = r[g];
  end
`endif

endmodule
